// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Groups the request and response channels of both requesters together with
// the shared ALU connection of alu_arbiter.
//
// Parameter:
//   DATA_W      operand width; ALU results are DATA_W+1 bits wide.
//
// Signals (directions shown from the arbiter's side, modport slave):
//   req0_/req1_  valid(in) ready(out) op(in) a(in) b(in)   request channels
//   rsp0_/rsp1_  valid(out) ready(in) out(out) zero(out) cout(out)
//                                                         response channels
//   alu_en, alu_op_sel, alu_in1, alu_in2                  (out) ALU control/operands
//   alu_out, alu_zero, alu_cout                           (in)  ALU result/flags
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment: both requesters plus the ALU
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W:0]   rsp0_out;
  logic              rsp0_zero;
  logic              rsp0_cout;

  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W:0]   rsp1_out;
  logic              rsp1_zero;
  logic              rsp1_cout;

  logic              alu_en;
  logic              alu_op_sel;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [DATA_W:0]   alu_out;
  logic              alu_zero;
  logic              alu_cout;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_out, rsp0_zero, rsp0_cout,
    output rsp1_valid, rsp1_out, rsp1_zero, rsp1_cout,
    input  rsp0_ready, rsp1_ready,
    output alu_en, alu_op_sel, alu_in1, alu_in2,
    input  alu_out, alu_zero, alu_cout
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_out, rsp0_zero, rsp0_cout,
    input  rsp1_valid, rsp1_out, rsp1_zero, rsp1_cout,
    output rsp0_ready, rsp1_ready,
    input  alu_en, alu_op_sel, alu_in1, alu_in2,
    output alu_out, alu_zero, alu_cout
  );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external add/NAND ALU between two requesters. An operation is
// accepted in IDLE, runs through the ALU for exactly one EXEC cycle, and its
// result is held in RESP until the requester takes it. One op in flight.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    alu_arbiter_if.slave - request/response channels of both
//          requesters and the ALU operand/result connection
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  when defined, port 0 always wins a tie; otherwise
//                          ties are resolved round-robin via last_grant.
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_last_grant;
  logic              r_grant;
  logic              r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;

  logic [1:0]        w_req_valid;
  logic [1:0]        w_req_ready;
  logic [1:0]        w_rsp_valid;
  logic [1:0]        w_rsp_ready;
  logic              w_any;
  logic              w_pick;
  logic              w_accept;
  logic              w_alu_en;

  logic              w_sel_op;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;

  assign w_req_valid = {bus.req1_valid, bus.req0_valid};
  assign w_rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  assign w_any       = |w_req_valid;

  // Winner among the valid requests. A lone request always wins; a tie goes
  // to the port that was not granted last (or to port 0 in fixed priority).
  always_comb begin
    w_pick = w_req_valid[1];
    if (&w_req_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w_pick = 1'b0;
`else
      w_pick = ~r_last_grant;
`endif
    end
  end

  assign w_sel_op = w_pick ? bus.req1_op : bus.req0_op;
  assign w_sel_a  = w_pick ? bus.req1_a  : bus.req0_a;
  assign w_sel_b  = w_pick ? bus.req1_b  : bus.req0_b;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs. Request readiness depends only on the
  // state and the request valids, never on the response-side ready.
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 2'b00;
    w_rsp_valid  = 2'b00;
    w_accept     = 1'b0;
    w_alu_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_req_ready  = w_pick ? 2'b10 : 2'b01;
          w_accept     = 1'b1;
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        w_alu_en     = 1'b1;
        w_state_next = RESP;
      end
      RESP: begin
        w_rsp_valid = r_grant ? 2'b10 : 2'b01;
        if (w_rsp_ready[r_grant]) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Latched operation. These registers also drive the ALU operand pins, so
  // the ALU inputs keep their last values outside EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_op         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_pick;
      r_grant      <= w_pick;
      r_op         <= w_sel_op;
      r_a          <= w_sel_a;
      r_b          <= w_sel_b;
    end
  end

  // Per-port response registers: loaded from the ALU at the end of EXEC for
  // the granted port only, so the other port's last result is untouched.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      localparam logic PORT = 1'(gi);
      logic [DATA_W:0] r_out;
      logic            r_zero;
      logic            r_cout;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_out  <= '0;
          r_zero <= 1'b0;
          r_cout <= 1'b0;
        end else if ((r_state == EXEC) && (r_grant == PORT)) begin
          r_out  <= bus.alu_out;
          r_zero <= bus.alu_zero;
          r_cout <= bus.alu_cout;
        end
      end
    end
  endgenerate

  assign bus.req0_ready = w_req_ready[0];
  assign bus.req1_ready = w_req_ready[1];

  assign bus.rsp0_valid = w_rsp_valid[0];
  assign bus.rsp0_out   = g_rsp[0].r_out;
  assign bus.rsp0_zero  = g_rsp[0].r_zero;
  assign bus.rsp0_cout  = g_rsp[0].r_cout;

  assign bus.rsp1_valid = w_rsp_valid[1];
  assign bus.rsp1_out   = g_rsp[1].r_out;
  assign bus.rsp1_zero  = g_rsp[1].r_zero;
  assign bus.rsp1_cout  = g_rsp[1].r_cout;

  assign bus.alu_en     = w_alu_en;
  assign bus.alu_op_sel = r_op;
  assign bus.alu_in1    = r_a;
  assign bus.alu_in2    = r_b;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit add/NAND ALU between two requesters, for example the execute stage and the branch/address-compute path. Each requester uses a valid/ready request channel and a valid/ready response channel. The block sequences each operation through the combinational ALU: accept, execute, then hold the response. Only one operation is in flight at a time.

## Interface
Parameters:
- `DATA_W`, default 16: operand width. The ALU result is `DATA_W+1` bits.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when high together with valid.
- `req0_op` / `req1_op`  in  1  operation select: 0 = add, 1 = NAND.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  `DATA_W`  operands.
- `rsp0_valid` / `rsp1_valid`  out  1  response present.
- `rsp0_ready` / `rsp1_ready`  in  1  requester consumes the response.
- `rsp0_out` / `rsp1_out`  out  `DATA_W+1`  captured ALU result.
- `rsp0_zero`, `rsp0_cout` / `rsp1_zero`, `rsp1_cout`  out  1  captured ALU flags.
- `alu_en`  out  1  ALU enable.
- `alu_op_sel`  out  1  ALU operation select.
- `alu_in1`, `alu_in2`  out  `DATA_W`  ALU operands.
- `alu_out`  in  `DATA_W+1`  ALU result.
- `alu_zero`, `alu_cout`  in  1  ALU flags.

## Operation
FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - `reqN_ready` is 1 only for the port selected by arbitration, and only when at least one valid is high. Otherwise both readies are 0.
  - On handshake: latch op, a, b and the granted port index; update `last_grant`; go to EXEC.
- **EXEC** (exactly 1 cycle):
  - `alu_en`=1; `alu_op_sel`, `alu_in1`, `alu_in2` are driven from the latched values.
  - At the clock edge, capture `alu_out`, `alu_zero`, `alu_cout` into the granted port's response registers; go to RESP.
- **RESP:**
  - `rspN_valid`=1 for the granted port only.
  - Response data is stable while valid is high.
  - On `rspN_ready`: go to IDLE.
  - No request is accepted in RESP.

Arbitration:
- Round-robin. If both requests are valid, grant the port other than `last_grant`.
- If only one request is valid, grant that port regardless of `last_grant`.
- `last_grant` resets to 1, so port 0 wins the first tie.

Outside EXEC:
- `alu_en`=0.
- `alu_op_sel`, `alu_in1`, `alu_in2` hold their last latched values.

Flags:
- Passed through exactly as the ALU produces them; the block does not reinterpret them.
- `zero` is 1 when `out[15:0]`==0 or when in1==in2 (with the ALU enabled).
- For NAND, `cout`=0 and `out[16]`=0.

Reset (rst_n low at a clock edge) forces:
- FSM to IDLE.
- `rsp0_valid` and `rsp1_valid` = 0.
- Response data and flags = 0.
- `alu_en`=0; `alu_op_sel`, `alu_in1`, `alu_in2` = 0.
- `last_grant`=1.

Reset applied in EXEC or RESP discards the in-flight operation; no response is issued for it.

Requester rules:
- A requester must hold valid and operands stable until ready.
- Dropping valid before ready is permitted; nothing is latched in that case.

## Timing
- Handshake in cycle N (IDLE); EXEC in N+1; `rspN_valid` high from N+2.
- Minimum 3 cycles per operation. Back-to-back: the next request can be accepted in the cycle after the response handshake.
- `reqN_ready` is combinational from state and the valids. It has no combinational dependency on `rspN_ready`.
- Response backpressure is unbounded: RESP is held with all outputs frozen.
- Simultaneous `req0_valid` and `req1_valid` in IDLE: exactly one handshake occurs; the other port sees ready=0.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. Port 0 always wins when both are valid; `last_grant` is ignored and still updated.
  - Undefined (default): round-robin as described above.

## Test plan
- Port 0 only, add 0xFFFF + 0x0001, `rsp0_ready`=1 -> at N+2 `rsp0_out`=0x10000, cout=1, zero=1, `rsp1_valid` stays 0.
- Port 1 only, NAND 0xFFFF, 0xFFFF -> `rsp1_out`=0x00000, cout=0, zero=1. Then add 0x0005 + 0x0005 -> out=0x0000A, cout=0, zero=1 (equality rule).
- Both valid continuously for 4 ops, responses always ready -> grant order 0,1,0,1. Each response matches its own operands; one acceptance every 3 cycles.
- `rsp1_ready` held low for 5 cycles during RESP -> `rsp1_valid` held, data stable, both `reqN_ready`=0. Release -> IDLE the next cycle.
- `rst_n` low during EXEC for one cycle -> no `rsp` valid ever appears for that op. `alu_en`=0 after the edge. A later tie grants port 0.
- With `ALU_ARB_FIXED_PRIO_EN` defined, both valid for 3 ops -> grants 0,0,0, port 1 starved until `req0_valid` drops.
